beam_dwell_sequencer: RTL and testbench

//   Downstream of the 8D beam steering controller. Buffers quantized beam step commands
//   (az/el step, centre = 8) and issues them to the phased-array beamformer over a

---
 rtl/beam_dwell_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_beam_dwell_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/beam_dwell_sequencer.sv
// Buffers quantized beam step commands, issues them to the beamformer over valid/ready,
// then enforces a phase-shifter settle time and a fixed receive dwell window per command.
module beam_dwell_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int DWELL_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_az_step,
    input  logic [3:0]  cmd_el_step,
    output logic        bfm_valid,
    input  logic        bfm_ready,
    output logic [3:0]  bfm_az_step,
    output logic [3:0]  bfm_el_step,
    output logic        dwell_start,
    output logic        dwell_active,
    output logic [2:0]  fifo_level,
    output logic [15:0] stat_dwells,
    output logic [15:0] stat_dropped
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [3:0] CTR = 4'd8;

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, DWELL, CENTER} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      cur_az_q, cur_az_d, cur_el_q, cur_el_d;
    logic [3:0]      bfm_az_q, bfm_az_d, bfm_el_q, bfm_el_d;
    logic            bfm_valid_q, bfm_valid_d;
    logic            dwell_start_q, dwell_start_d;
    logic            dwell_active_q, dwell_active_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [DW-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [15:0]     stat_dwells_q, stat_dwells_d;
    logic [15:0]     stat_dropped_q, stat_dropped_d;

    logic       full, empty, push, drop, pop, xfer, dispatch;
    logic [3:0] head_az, head_el;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        cur_az_d       = cur_az_q;
        cur_el_d       = cur_el_q;
        bfm_az_d       = bfm_az_q;
        bfm_el_d       = bfm_el_q;
        bfm_valid_d    = bfm_valid_q;
        dwell_start_d  = 1'b0;
        dwell_active_d = dwell_active_q;
        settle_cnt_d   = settle_cnt_q;
        dwell_cnt_d    = dwell_cnt_q;
        stat_dwells_d  = stat_dwells_q;
        stat_dropped_d = stat_dropped_q;
        pop            = 1'b0;
        dispatch       = 1'b0;

        full    = (count_q == CW'(FIFO_DEPTH));
        empty   = (count_q == '0);
        head_az = mem_q[rd_ptr_q][7:4];
        head_el = mem_q[rd_ptr_q][3:0];
        xfer    = bfm_valid_q && bfm_ready;
        push    = cmd_valid && enable && (state_q != CENTER) && !full;
        drop    = cmd_valid && enable && (state_q != CENTER) && full;

        if (drop && stat_dropped_q != '1)
            stat_dropped_d = stat_dropped_q + 16'd1;

        if (!enable && (state_q == LOAD || state_q == SETTLE || state_q == DWELL)) begin
            // a handshake completing in the abort cycle still moves the beam
            if (state_q == LOAD && xfer) begin
                cur_az_d = bfm_az_q;
                cur_el_d = bfm_el_q;
            end
            dwell_active_d = 1'b0;
            settle_cnt_d   = '0;
            dwell_cnt_d    = '0;
            if (cur_az_d != CTR || cur_el_d != CTR) begin
                state_d     = CENTER;
                bfm_valid_d = 1'b1;
                bfm_az_d    = CTR;
                bfm_el_d    = CTR;
            end else begin
                state_d     = IDLE;
                bfm_valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!enable) begin
                        if (cur_az_q != CTR || cur_el_q != CTR) begin
                            state_d     = CENTER;
                            bfm_valid_d = 1'b1;
                            bfm_az_d    = CTR;
                            bfm_el_d    = CTR;
                        end
                    end else if (!empty) begin
                        dispatch = 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        cur_az_d     = bfm_az_q;
                        cur_el_d     = bfm_el_q;
                        bfm_valid_d  = 1'b0;
                        settle_cnt_d = SW'(SETTLE_CYCLES);
                        state_d      = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == SW'(1)) begin
                        state_d        = DWELL;
                        dwell_active_d = 1'b1;
                        dwell_start_d  = 1'b1;
                        dwell_cnt_d    = DW'(DWELL_CYCLES);
                    end else begin
                        settle_cnt_d = settle_cnt_q - SW'(1);
                    end
                end
                DWELL: begin
                    if (dwell_cnt_q == DW'(1)) begin
                        if (stat_dwells_q != '1)
                            stat_dwells_d = stat_dwells_q + 16'd1;
                        dwell_active_d = 1'b0;
                        if (!empty)
                            dispatch = 1'b1;
                        else
                            state_d = IDLE;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - DW'(1);
                    end
                end
                CENTER: begin
                    if (xfer) begin
                        cur_az_d    = CTR;
                        cur_el_d    = CTR;
                        bfm_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // a head equal to the current position needs no move, so dwell starts directly
        if (dispatch) begin
            pop = 1'b1;
            if (head_az == cur_az_q && head_el == cur_el_q) begin
                state_d        = DWELL;
                dwell_active_d = 1'b1;
                dwell_start_d  = 1'b1;
                dwell_cnt_d    = DW'(DWELL_CYCLES);
            end else begin
                state_d     = LOAD;
                bfm_valid_d = 1'b1;
                bfm_az_d    = head_az;
                bfm_el_d    = head_el;
            end
        end

        if (!enable) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {cmd_az_step, cmd_el_step};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            cur_az_q       <= CTR;
            cur_el_q       <= CTR;
            bfm_az_q       <= CTR;
            bfm_el_q       <= CTR;
            bfm_valid_q    <= 1'b0;
            dwell_start_q  <= 1'b0;
            dwell_active_q <= 1'b0;
            settle_cnt_q   <= '0;
            dwell_cnt_q    <= '0;
            stat_dwells_q  <= '0;
            stat_dropped_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            cur_az_q       <= cur_az_d;
            cur_el_q       <= cur_el_d;
            bfm_az_q       <= bfm_az_d;
            bfm_el_q       <= bfm_el_d;
            bfm_valid_q    <= bfm_valid_d;
            dwell_start_q  <= dwell_start_d;
            dwell_active_q <= dwell_active_d;
            settle_cnt_q   <= settle_cnt_d;
            dwell_cnt_q    <= dwell_cnt_d;
            stat_dwells_q  <= stat_dwells_d;
            stat_dropped_q <= stat_dropped_d;
        end
    end

    assign bfm_valid    = bfm_valid_q;
    assign bfm_az_step  = bfm_az_q;
    assign bfm_el_step  = bfm_el_q;
    assign dwell_start  = dwell_start_q;
    assign dwell_active = dwell_active_q;
    assign fifo_level   = 3'(count_q);
    assign stat_dwells  = stat_dwells_q;
    assign stat_dropped = stat_dropped_q;

endmodule

// File: tb/tb_beam_dwell_sequencer.sv
// Self-checking bench for beam_dwell_sequencer: beamformer transfers are scored against
// a queue filled when commands are driven; timing and status are checked per scenario.
module tb_beam_dwell_sequencer;

    logic        clk = 1'b0;
    logic        rst, enable, cmd_valid, bfm_ready;
    logic [3:0]  cmd_az_step, cmd_el_step;
    logic        bfm_valid, dwell_start, dwell_active;
    logic [3:0]  bfm_az_step, bfm_el_step;
    logic [2:0]  fifo_level;
    logic [15:0] stat_dwells, stat_dropped;

    beam_dwell_sequencer #(
        .FIFO_DEPTH   (4),
        .SETTLE_CYCLES(8),
        .DWELL_CYCLES (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cmd_valid   (cmd_valid),
        .cmd_az_step (cmd_az_step),
        .cmd_el_step (cmd_el_step),
        .bfm_valid   (bfm_valid),
        .bfm_ready   (bfm_ready),
        .bfm_az_step (bfm_az_step),
        .bfm_el_step (bfm_el_step),
        .dwell_start (dwell_start),
        .dwell_active(dwell_active),
        .fifo_level  (fifo_level),
        .stat_dwells (stat_dwells),
        .stat_dropped(stat_dropped)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  exp_q [$];

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // scoreboard: every completed beamformer handshake must match the next expected step
    always @(negedge clk) begin
        if (!rst && bfm_valid && bfm_ready) begin
            check("bfm_xfer_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0)
                check("bfm_xfer_data", {bfm_az_step, bfm_el_step}, exp_q.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] e);
        cmd_valid   = 1'b1;
        cmd_az_step = a;
        cmd_el_step = e;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_valid;
        int n = 0;
        while (!bfm_valid && n < 50) begin tick(); n++; end
    endtask

    task automatic wait_start(input string tag, output int unsigned at);
        int n = 0;
        while (!dwell_start && n < 300) begin tick(); n++; end
        check({tag, "_dwell_seen"}, dwell_start, 1);
        at = cyc;
    endtask

    task automatic dwell_len(output int unsigned len, output int unsigned starts);
        len = 0;
        starts = 0;
        while (dwell_active && len < 100) begin
            if (dwell_start) starts++;
            len++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0, at, len, starts, r;
        int n;
        logic seen, stable;
        logic [7:0] burst [6];
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h99};

        rst = 1'b1; enable = 1'b1; cmd_valid = 1'b0; bfm_ready = 1'b1;
        cmd_az_step = '0; cmd_el_step = '0;
        repeat (3) tick();
        check("rst_bfm_valid", bfm_valid, 0);
        check("rst_bfm_step", {bfm_az_step, bfm_el_step}, 8'h88);
        check("rst_dwell", {dwell_start, dwell_active}, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_stats", {stat_dwells, stat_dropped}, 0);
        rst = 1'b0;
        tick();

        // 1: move to (3,12), full latency chain
        t0 = cyc;
        exp_q.push_back(8'h3C);
        send(4'd3, 4'd12);
        wait_valid();
        check("t1_bfm_latency", cyc - t0, 2);
        check("t1_bfm_data", {bfm_az_step, bfm_el_step}, 8'h3C);
        tick();
        check("t1_bfm_one_cycle", bfm_valid, 0);
        wait_start("t1", at);
        check("t1_dwell_latency", at - t0, 11);
        dwell_len(len, starts);
        check("t1_dwell_len", len, 32);
        check("t1_dwell_start_pulses", starts, 1);
        check("t1_stat_dwells", stat_dwells, 1);

        // 2: beamformer stalls for 10 cycles
        t0 = cyc;
        bfm_ready = 1'b0;
        exp_q.push_back(8'h55);
        send(4'd5, 4'd5);
        wait_valid();
        check("t2_bfm_latency", cyc - t0, 2);
        stable = 1'b1;
        repeat (10) begin
            if (!bfm_valid || {bfm_az_step, bfm_el_step} != 8'h55) stable = 1'b0;
            tick();
        end
        check("t2_held_stable", stable, 1);
        bfm_ready = 1'b1;
        r = cyc;
        tick();
        check("t2_valid_drops", bfm_valid, 0);
        wait_start("t2", at);
        check("t2_settle_after_ready", at - r, 9);
        dwell_len(len, starts);
        check("t2_stat_dwells", stat_dwells, 2);

        // 3: burst of six commands during a dwell, FIFO holds four
        exp_q.push_back(8'h77);
        send(4'd7, 4'd7);
        wait_start("t3", at);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(burst[i]);
            send(burst[i][7:4], burst[i][3:0]);
        end
        check("t3_fifo_full", fifo_level, 4);
        check("t3_dropped", stat_dropped, 2);
        n = 0;
        while (stat_dwells < 7 && n < 2000) begin tick(); n++; end
        check("t3_stat_dwells", stat_dwells, 7);
        tick();
        check("t3_drained", {dwell_active, bfm_valid, fifo_level}, 0);

        // 4: command equal to current position (4,4) skips the move
        t0 = cyc;
        send(4'd4, 4'd4);
        seen = 1'b0;
        n = 0;
        while (!dwell_start && n < 50) begin
            if (bfm_valid) seen = 1'b1;
            tick();
            n++;
        end
        check("t4_dwell_latency", cyc - t0, 2);
        check("t4_no_bfm_valid", seen, 0);
        dwell_len(len, starts);
        check("t4_dwell_len", len, 32);
        check("t4_stat_dwells", stat_dwells, 8);

        // 5: disable mid-dwell with two queued, beam re-centres
        exp_q.push_back(8'hA2);
        send(4'd10, 4'd2);
        wait_start("t5", at);
        send(4'd11, 4'd3);
        send(4'd12, 4'd4);
        check("t5_queued", fifo_level, 2);
        enable = 1'b0;
        exp_q.push_back(8'h88);
        tick();
        check("t5_dwell_aborted", dwell_active, 0);
        check("t5_fifo_flushed", fifo_level, 0);
        check("t5_center_valid", bfm_valid, 1);
        check("t5_center_step", {bfm_az_step, bfm_el_step}, 8'h88);
        repeat (3) send(4'd1, 4'd1);
        check("t5_ignored_fifo", fifo_level, 0);
        check("t5_ignored_bfm", bfm_valid, 0);
        check("t5_stat_dwells", stat_dwells, 8);
        check("t5_stat_dropped", stat_dropped, 2);
        enable = 1'b1;
        tick();
        check("t5_queue_drained", exp_q.size(), 0);

        // 6: reset during a stalled handshake
        bfm_ready = 1'b0;
        send(4'd1, 4'd15);
        wait_valid();
        check("t6_in_load", {bfm_valid, bfm_az_step, bfm_el_step}, 9'h11F);
        rst = 1'b1;
        tick();
        check("t6_rst_valid", bfm_valid, 0);
        check("t6_rst_step", {bfm_az_step, bfm_el_step}, 8'h88);
        check("t6_rst_fifo", fifo_level, 0);
        check("t6_rst_stats", {stat_dwells, stat_dropped}, 0);
        rst = 1'b0;
        bfm_ready = 1'b1;
        repeat (3) tick();
        check("t6_no_pending", {bfm_valid, dwell_active}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
